neuron_mac_seq: RTL
===================

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 SHALL have parameter N_INPUTS, default 784, number of inputs per neuron (>=2).
REQ-002 SHALL have parameter DATA_W, default 16, width of data, weights, bias and output (signed two's complement).
REQ-003 SHALL have parameter FRAC_W, default 8, fractional bits of the data, weight, bias and output fixed-point format.
REQ-004 SHALL have parameter NEURON_W, default 8, neuron index width.
REQ-005 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(N_INPUTS)+1, accumulator width.
REQ-006 SHALL have localparam IDX_W = $clog2(N_INPUTS).
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 start  input  1  begin one neuron evaluation (sampled in IDLE only).
REQ-011 neuron_id  input  NEURON_W  neuron index, latched on accepted start.
REQ-012 in_valid  input  1  in_data valid.
REQ-013 in_data  input  DATA_W  activation from previous layer, index order 0..N_INPUTS-1.
REQ-014 in_ready  output  1  engine accepts in_data.
REQ-015 w_addr  output  NEURON_W+IDX_W  weight address {neuron_id_q, idx}.
REQ-016 w_data  input  DATA_W  weight at w_addr, combinational read.
REQ-017 b_addr  output  NEURON_W  bias address (neuron_id_q).
REQ-018 b_data  input  DATA_W  bias at b_addr, combinational read.
REQ-019 out_valid  output  1  out_data valid.
REQ-020 out_data  output  DATA_W  neuron result.
REQ-021 out_ready  input  1  consumer accepts out_data.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 SHALL implement states IDLE, ACCUM, BIAS, OUT.
REQ-024 IDLE: start=1 -> latch neuron_id, clear accumulator and idx, go to ACCUM next cycle.
REQ-025 ACCUM: in_ready=1; each cycle with in_valid&in_ready adds signed(in_data)*signed(w_data) to the accumulator and increments idx; in_valid=0 stalls without change.
REQ-026 ACCUM: acceptance at idx==N_INPUTS-1 -> BIAS next cycle; idx never exceeds N_INPUTS-1.
REQ-027 BIAS: add signed(b_data) shifted left by FRAC_W into the accumulator, in_ready=0, go to OUT.
REQ-028 OUT entry: out_data = accumulator arithmetically shifted right by FRAC_W (floor), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], registered.
REQ-029 OUT: out_valid=1, out_data stable until out_valid&out_ready, then IDLE next cycle.
REQ-030 Latency: last input accepted at cycle k -> out_valid high at cycle k+2; minimum start-to-out_valid N_INPUTS+2 cycles.
REQ-031 start outside IDLE SHALL be ignored; neuron_id changes after latching SHALL have no effect.
REQ-032 Accumulator SHALL never overflow for any input values (ACC_W sizing); saturation only at the output.
REQ-033 in_ready SHALL be 0 in IDLE, BIAS, OUT.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, accumulator 0, idx 0, neuron_id_q 0, out_data 0, out_valid 0, in_ready 0, busy 0.
REQ-035 Reset mid-ACCUM or mid-OUT SHALL discard the partial evaluation; no out_valid pulse follows.

Configuration
REQ-036 Macro NEURON_RELU_EN: when defined, the saturated result SHALL pass through ReLU (negative -> 0) before registering to out_data (hidden layers).
REQ-037 Without NEURON_RELU_EN, out_data SHALL be the signed saturated result unmodified (output layer).

Verification (N_INPUTS=4, DATA_W=16, FRAC_W=8)
REQ-038 Inputs 0x0100 x4, weights 0x0100 x4, bias 0x0080, continuous in_valid -> out_data 0x0480, out_valid exactly 2 cycles after 4th acceptance.
REQ-039 Inputs 0x7FFF x4, weights 0x7FFF x4, bias 0x7FFF -> out_data 0x7FFF (saturated); negative mirror case -> 0x8000 without macro.
REQ-040 Inputs 0x0100 x4, weights 0xFF00 x4, bias 0 -> out_data 0x0000 with NEURON_RELU_EN, 0xFC00 without.
REQ-041 in_valid toggled every other cycle plus out_ready held low 5 cycles -> same result as REQ-038, out_data stable while stalled, start pulses during busy ignored.
REQ-042 rst asserted after 2 accepted inputs -> all outputs 0 same cycle; new start then REQ-038 stimulus -> 0x0480.
REQ-043 Two back-to-back evaluations, neuron_id 3 then 5 -> w_addr upper bits 3 then 5, b_addr 3 then 5.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Sequential fixed-point neuron: one MAC per accepted input, then bias, floor-shift and saturate; result
// registered two cycles after the last input and held until out_ready. NEURON_RELU_EN adds ReLU on the output.
module neuron_mac_seq #(
  parameter int N_INPUTS = 784,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int NEURON_W = 8,
  parameter int ACC_W    = 2*DATA_W + $clog2(N_INPUTS) + 1,
  localparam int IDX_W   = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NEURON_W-1:0]       neuron_id,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NEURON_W+IDX_W-1:0] w_addr,
  input  logic [DATA_W-1:0]         w_data,
  output logic [NEURON_W-1:0]       b_addr,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_INPUTS - 1);
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                     state_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [IDX_W-1:0]           idx_q;
  logic [NEURON_W-1:0]        nid_q;
  logic [DATA_W-1:0]          out_data_q;
  logic                       out_valid_q;
  logic                       in_ready_q;
  logic                       busy_q;

  logic signed [2*DATA_W-1:0] prod_d;
  logic signed [ACC_W-1:0]    acc_mac_d;
  logic signed [ACC_W-1:0]    bias_ext_d;
  logic signed [ACC_W-1:0]    acc_bias_d;
  logic signed [ACC_W-1:0]    shifted_d;
  logic [ACC_W-DATA_W:0]      shifted_top_d;
  logic                       fits_d;
  logic [DATA_W-1:0]          sat_d;
  logic [DATA_W-1:0]          out_d;
  logic                       accept_d;
  logic                       last_d;

  assign accept_d = in_valid & in_ready_q;
  assign last_d   = (idx_q == IDX_LAST);

  // The accumulator is wide enough for N_INPUTS full-scale products plus the bias.
  assign prod_d     = $signed(in_data) * $signed(w_data);
  assign acc_mac_d  = acc_q + {{(ACC_W-2*DATA_W){prod_d[2*DATA_W-1]}}, prod_d};
  assign bias_ext_d = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data} <<< FRAC_W;
  assign acc_bias_d = acc_q + bias_ext_d;

  // Floor shift, then saturate if the bits above the output sign are not a pure sign extension.
  assign shifted_d     = acc_bias_d >>> FRAC_W;
  assign shifted_top_d = shifted_d[ACC_W-1:DATA_W-1];
  assign fits_d        = (&shifted_top_d) | ~(|shifted_top_d);

  always_comb begin
    sat_d = shifted_d[DATA_W-1:0];
    if (!fits_d) begin
      sat_d = shifted_d[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

`ifdef NEURON_RELU_EN
  assign out_d = sat_d[DATA_W-1] ? '0 : sat_d;
`else
  assign out_d = sat_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      nid_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            nid_q      <= neuron_id;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept_d) begin
            acc_q <= acc_mac_d;
            if (last_d) begin
              in_ready_q <= 1'b0;
              state_q    <= BIAS;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        BIAS: begin
          acc_q       <= acc_bias_d;
          out_data_q  <= out_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign w_addr    = {nid_q, idx_q};
  assign b_addr    = nid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
